// File: rtl/led_sequencer.sv
// led_sequencer: ticked LED pattern generator that writes the LED PIO over Avalon-MM, with a priority override path.
module led_sequencer #(
  parameter int DIV_WIDTH = 24,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 override_valid,
  input  logic [LED_WIDTH-1:0] override_data,
  output logic                 override_ready,
  output logic [1:0]           m_address,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [31:0]          m_writedata,
  input  logic                 m_waitrequest,
  output logic [LED_WIDTH-1:0] pattern,
  output logic                 busy
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state;
  logic [DIV_WIDTH-1:0] cnt, last;
  logic [LED_WIDTH-1:0] pat, buf_data, adv, shl, shr;
  logic dir, seq_pending, buf_full, tick, capture, adv_dir;
  assign last = (period == '0) ? '0 : period - DIV_WIDTH'(1);
  assign tick = enable && (cnt == last);
  assign capture = override_valid && !buf_full;
  assign shl = pat << 1;
  assign shr = pat >> 1;
  // dir: 0 moves left, 1 moves right; bounce flips once the edge bit is reached
  assign adv = (mode == 2'd0) ? {pat[LED_WIDTH-2:0], pat[LED_WIDTH-1]} :
               (mode == 2'd1) ? {pat[0], pat[LED_WIDTH-1:1]} :
               (mode == 2'd2) ? (dir ? shr : shl) : pat + LED_WIDTH'(1);
  assign adv_dir = ((mode == 2'd2) && (dir ? shr[0] : shl[LED_WIDTH-1])) ? ~dir : dir;
  assign m_address = '0;
  assign m_chipselect = (state == WRITE);
  assign m_write_n = (state != WRITE);
  assign override_ready = !buf_full;
  assign busy = (state == WRITE) | seq_pending | buf_full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pat <= LED_WIDTH'(1);
      dir <= 1'b0;
      seq_pending <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
      m_writedata <= '0;
      pattern <= '0;
    end else begin
      cnt <= (!enable || tick) ? '0 : cnt + DIV_WIDTH'(1);
      if (state == IDLE) begin
        if (buf_full) begin
          m_writedata <= 32'(buf_data);
          buf_full <= 1'b0;
          state <= WRITE;
        end else if (seq_pending) begin
          m_writedata <= 32'(pat);
          seq_pending <= 1'b0;
          state <= WRITE;
        end
      end else if (!m_waitrequest) begin
        pattern <= m_writedata[LED_WIDTH-1:0];
        state <= IDLE;
      end
      // placed last so a fresh tick or override outranks the launch-side clears above
      if (capture) begin
        buf_data <= override_data;
        buf_full <= 1'b1;
        pat <= override_data;
        seq_pending <= 1'b0;
      end else if (tick) begin
        pat <= adv;
        dir <= adv_dir;
        seq_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: scoreboard bench; expected PIO writes are queued with stimulus and popped on each accepted write.
module tb_led_sequencer;
  localparam int W = 8;
  localparam int DW = 24;
  localparam logic [45:0] RST_OUTS = {1'b0, 1'b1, 2'b00, 32'h0, 8'h00, 1'b1, 1'b0};
  logic clk = 0, reset = 1, enable = 0, override_valid = 0, m_waitrequest = 0;
  logic [1:0] mode = 0;
  logic [DW-1:0] period = 1;
  logic [W-1:0] override_data = 0;
  logic override_ready, m_chipselect, m_write_n, busy;
  logic [1:0] m_address;
  logic [31:0] m_writedata;
  logic [W-1:0] pattern;
  logic [45:0] outs;
  int checks = 0, errors = 0, cyc_n = 0;
  logic [W-1:0] exp_q[$];

  led_sequencer #(.DIV_WIDTH(DW), .LED_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .override_valid(override_valid), .override_data(override_data), .override_ready(override_ready),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .pattern(pattern), .busy(busy)
  );

  assign outs = {m_chipselect, m_write_n, m_address, m_writedata, pattern, override_ready, busy};
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic pulse_tick();
    enable = 1;
    cyc();
    enable = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    enable = 0;
    mode = 0;
    period = 1;
    override_valid = 0;
    override_data = 0;
    m_waitrequest = 0;
    exp_q.delete();
    cyc();
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic wait_write(input int budget, output logic [31:0] d, output int len, output int at, output bit ok);
    ok = 0;
    len = 0;
    d = '0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (m_chipselect && !m_write_n) begin
        len++;
        if (!m_waitrequest) begin
          d = m_writedata;
          at = cyc_n;
          ok = 1;
        end
      end
      cyc();
    end
  endtask

  task automatic count_strobes(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (m_chipselect) c++;
      cyc();
    end
  endtask

  task automatic override(input logic [W-1:0] v);
    override_data = v;
    override_valid = 1;
    exp_q.push_back(v);
    cyc();
    override_valid = 0;
  endtask

  task automatic test_reset();
    int c;
    reset = 1;
    cyc();
    cyc();
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL reset_outs got %h want %h", outs, RST_OUTS); end
    reset = 0;
    cyc();
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL reset_release got %h want %h", outs, RST_OUTS); end
    count_strobes(10, c);
    checks++;
    if (c !== 0) begin errors++; $display("FAIL reset_no_write got %0d want 0", c); end
  endtask

  task automatic test_rotate();
    logic [31:0] d;
    int len, at, prev, c;
    bit ok, seen;
    logic [W-1:0] e;
    do_reset();
    period = 4;
    enable = 1;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h08);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_write(12, d, len, at, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== 32'(e)) begin errors++; $display("FAIL rotate_data[%0d] got %h want %h", k, d, e); end
      checks++;
      if (len !== 1) begin errors++; $display("FAIL rotate_strobe_len[%0d] got %0d want 1", k, len); end
      checks++;
      if (pattern !== e) begin errors++; $display("FAIL rotate_pattern[%0d] got %h want %h", k, pattern, e); end
      if (k > 0) begin
        checks++;
        if (at - prev !== 4) begin errors++; $display("FAIL rotate_spacing[%0d] got %0d want 4", k, at - prev); end
      end
      prev = at;
    end
    exp_q.push_back(8'h10);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      seen = busy;
      if (!seen) cyc();
    end
    enable = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL rotate_pending got busy=0 want busy=1"); end
    wait_write(8, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL rotate_after_disable got %h want %h", d, e); end
    count_strobes(12, c);
    checks++;
    if (c !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rotate_stopped got strobes=%0d busy=%b want 0 0", c, busy); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    int len, at;
    bit ok;
    logic [W-1:0] e;
    logic [W-1:0] vals[10] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10};
    do_reset();
    mode = 2'd2;
    period = 1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vals[i]);
      pulse_tick();
      wait_write(6, d, len, at, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== 32'(e) || pattern !== e) begin
        errors++;
        $display("FAIL bounce[%0d] got data=%h pattern=%h want %h", i, d, pattern, e);
      end
    end
  endtask

  task automatic test_override_stall();
    logic [31:0] d;
    int len, at, strobes;
    bit ok;
    logic [W-1:0] e;
    do_reset();
    m_waitrequest = 1;
    override(8'h5A);
    checks++;
    if (override_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_capture got ready=%b busy=%b want 0 1", override_ready, busy); end
    strobes = 0;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (m_chipselect && !m_write_n) strobes++;
      checks++;
      if (m_writedata !== 32'h0000005A || pattern !== 8'h00) begin
        errors++;
        $display("FAIL ovr_stall[%0d] got data=%h pattern=%h want 0000005a 00", k, m_writedata, pattern);
      end
      if (k == 0) begin
        checks++;
        if (override_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready_launch got %b want 1", override_ready); end
      end
      if (k == 3) begin
        d = m_writedata;
        m_waitrequest = 0;
      end
    end
    cyc();
    e = exp_q.pop_front();
    checks++;
    if (strobes !== 4 || m_chipselect !== 1'b0) begin errors++; $display("FAIL ovr_strobe_len got %0d cs=%b want 4 0", strobes, m_chipselect); end
    checks++;
    if (d !== 32'(e) || pattern !== e) begin errors++; $display("FAIL ovr_accept got data=%h pattern=%h want %h", d, pattern, e); end
    exp_q.push_back(8'hB4);
    pulse_tick();
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL ovr_next_tick got %h want %h", d, e); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    int len, at, c;
    bit ok;
    logic [W-1:0] e;
    do_reset();
    period = 4;
    override(8'h10);
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL coll_preload got %h want %h", d, e); end
    enable = 1;
    cyc();
    cyc();
    cyc();
    override(8'h3C);
    enable = 0;
    wait_write(8, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL coll_data got %h want %h", d, e); end
    count_strobes(8, c);
    checks++;
    if (c !== 0 || pattern !== 8'h3C) begin errors++; $display("FAIL coll_single got strobes=%0d pattern=%h want 0 3c", c, pattern); end
    period = 1;
    exp_q.push_back(8'h78);
    pulse_tick();
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL coll_next_tick got %h want %h", d, e); end
  endtask

  task automatic test_increment();
    logic [31:0] d;
    int len, at, prev, c;
    bit ok;
    logic [W-1:0] e;
    do_reset();
    mode = 2'd3;
    period = 0;
    override(8'hFE);
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL incr_preload got %h want %h", d, e); end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(k == 0 ? 8'hFF : 8'h00);
      pulse_tick();
      wait_write(6, d, len, at, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== 32'(e)) begin errors++; $display("FAIL incr_step[%0d] got %h want %h", k, d, e); end
    end
    enable = 1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h05);
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_write(8, d, len, at, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || d !== 32'(e)) begin errors++; $display("FAIL incr_coalesce[%0d] got %h want %h", k, d, e); end
      if (k > 0) begin
        checks++;
        if (at - prev !== 2) begin errors++; $display("FAIL incr_spacing[%0d] got %0d want 2", k, at - prev); end
      end
      prev = at;
    end
    enable = 0;
    exp_q.push_back(8'h07);
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL incr_drain got %h want %h", d, e); end
    count_strobes(8, c);
    checks++;
    if (c !== 0) begin errors++; $display("FAIL incr_quiet got %0d want 0", c); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    int len, at, c;
    bit ok;
    logic [W-1:0] e;
    do_reset();
    m_waitrequest = 1;
    override(8'h33);
    exp_q.delete();
    cyc();
    checks++;
    if (m_chipselect !== 1'b1) begin errors++; $display("FAIL rmw_in_write got cs=%b want 1", m_chipselect); end
    #3 reset = 1;
    #1;
    checks++;
    if (outs !== RST_OUTS) begin errors++; $display("FAIL rmw_async got %h want %h", outs, RST_OUTS); end
    cyc();
    reset = 0;
    m_waitrequest = 0;
    count_strobes(6, c);
    checks++;
    if (c !== 0 || outs !== RST_OUTS) begin errors++; $display("FAIL rmw_after got strobes=%0d outs=%h want 0 %h", c, outs, RST_OUTS); end
    exp_q.push_back(8'h02);
    pulse_tick();
    wait_write(6, d, len, at, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || d !== 32'(e)) begin errors++; $display("FAIL rmw_pat_reset got %h want %h", d, e); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_override_stall();
    test_collision();
    test_increment();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Autonomous Avalon-MM master that drives the 8-bit LED output PIO slave (address 0 data register).
- Advances an LED pattern on a programmable tick.
- Shares the single PIO write path between the internal sequencer and an external override requester; override has priority.
- Sits between the CPU-side control registers and the LED PIO.

Parameters:
DIV_WIDTH, 24, width of the tick period counter
LED_WIDTH, 8, pattern width; must match the PIO data width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  sequencer run; low holds the tick counter at 0
mode  input  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary increment
period  input  DIV_WIDTH  tick period in clk cycles; 0 treated as 1
override_valid  input  1  override write request
override_data  input  LED_WIDTH  override pattern
override_ready  output  1  override buffer empty, can accept
m_address  output  2  PIO address; always 0
m_chipselect  output  1  PIO chipselect
m_write_n  output  1  PIO write strobe, active low
m_writedata  output  32  {zero-extend, data}
m_waitrequest  input  1  fabric stall; tie 0 when the PIO is direct-connected
pattern  output  LED_WIDTH  mirror of the last value accepted by the PIO
busy  output  1  write in progress, or write pending

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, and forces every register immediately, including mid-write.
- Reset values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, pattern=0x00, override_ready=1, busy=0. Internal state after reset: internal pattern pat=0x01, bounce direction=left, counter=0, no pending writes.
- Tick counter:
  - When enable=1, the counter counts 0..P-1, where P=max(period,1).
  - The tick fires on the edge where counter==P-1; the counter then returns to 0.
  - When enable=0, the counter is held at 0 and no ticks occur.
  - A change to period takes effect when it is next compared.
- Pattern advance on tick, using mode as sampled at the tick:
  - 00: rotate left. 0x80 becomes 0x01.
  - 01: rotate right. 0x01 becomes 0x80.
  - 10: bounce. Shift one bit in the current direction. If the result has bit LED_WIDTH-1 set (moving left) or bit 0 set (moving right), flip the direction. Starting from 0x40 moving left: 0x80, then 0x40, then 0x20.
  - 11: increment modulo 2^LED_WIDTH. 0xFF becomes 0x00.
  - The tick sets seq_pending. A tick while seq_pending is already set still advances pat; writes coalesce and only the latest value is written.
- Override:
  - override_valid && override_ready captures override_data into a one-entry buffer.
  - On that same edge, pat is loaded with override_data, and any seq_pending is cleared because it is superseded.
  - override_ready=0 while the buffer is full.
  - If a tick coincides with the override capture, the override load wins and that tick's advance is discarded.
- Write FSM, states IDLE and WRITE:
  - IDLE, override buffer full: latch the buffer into m_writedata, free the buffer, go to WRITE.
  - IDLE, else if seq_pending: latch pat into m_writedata, clear seq_pending, go to WRITE.
  - IDLE, otherwise: remain in IDLE.
  - WRITE drives m_chipselect=1, m_write_n=0 and m_address=0. m_writedata is held stable.
  - WRITE with m_waitrequest=1: stay in WRITE.
  - WRITE with m_waitrequest=0: the write is accepted. pattern is set to m_writedata[LED_WIDTH-1:0], and the FSM returns to IDLE.
  - IDLE strobes: m_chipselect=0, m_write_n=1.
  - Minimum spacing is one IDLE cycle between writes.
- Latency:
  - Tick edge E sets seq_pending. WRITE is entered at E+1, so the strobe is visible in cycle E+1..E+2. pattern updates at E+2 when waitrequest=0.
  - Override capture at E produces the strobe after E+1 by the same rule.
- enable deasserting does not cancel a pending or in-flight write.
- busy = (state==WRITE) | seq_pending | buffer full.

Test Plan:
1. Hold reset high, toggle clk, release. Required: all outputs at their reset values, with pattern=0x00 and m_write_n=1. No write occurs until the first tick.
2. enable=1, mode=00, period=4, waitrequest=0. Required: writes of 0x02, 0x04, 0x08 every 4 cycles, each strobe exactly 1 cycle, pattern tracking each write. Deasserting enable stops further writes after any pending one completes.
3. mode=10, period=1, run 10 ticks. Required: written sequence 02, 04, 08, 10, 20, 40, 80, 40, 20, 10.
4. Override 0x5A with m_waitrequest held high for 3 cycles. Required: strobe held for 4 cycles with m_writedata=0x0000005A stable. override_ready low from capture until the WRITE launch. pattern becomes 0x5A after the write is accepted. The next tick writes 0xB4 (mode 00).
5. Override captured on the same edge as a tick, pat=0x10, mode 00. Required: exactly one write, value = override data. Next tick writes override<<1 (rotate).
6. mode=11, period=0, pat preloaded to 0xFE via override. Required: writes 0xFF then 0x00. Ticks arrive every cycle and coalesce, so successive written values skip.
7. Assert reset during WRITE. Required: m_chipselect drops to 0 the same cycle, without waiting for a clock edge, and all state returns to reset values.
